// File: rtl/hit_receiver_if.sv
// Signal bundle between the combat logic / sprite drawer and the hit reaction block.
// The master drives the hit and frame inputs; the slave is the hit_receiver itself.
interface hit_receiver_if;
    logic       hit_start;
    logic [6:0] damage;
    logic       frame_tick;
    logic [8:0] base_x;
    logic [8:0] pos_x;
    logic       flash;
    logic [6:0] hp;
    logic       busy;
    logic       done;
    logic       fainted;

    modport master (
        output hit_start, damage, frame_tick, base_x,
        input  pos_x, flash, hp, busy, done, fainted
    );

    modport slave (
        input  hit_start, damage, frame_tick, base_x,
        output pos_x, flash, hp, busy, done, fainted
    );
endinterface

// File: rtl/hit_receiver.sv
// Defender hit reaction: takes damage, then animates the knockback as
// push-out, a flashing hold, and a return, finishing with a one-clock done pulse.
//
// state  | meaning
// IDLE   | waiting for an accepted hit
// PUSH   | offset grows by one per frame tick up to KNOCK_DIST
// HOLD   | parked at full knockback for HOLD_FRAMES ticks, flash toggling
// RETURN | offset shrinks by one per frame tick back to zero
// DONE   | single-clock completion pulse
module hit_receiver #(
    parameter int HP_MAX      = 100,
    parameter int KNOCK_DIST  = 10,
    parameter int HOLD_FRAMES = 6
) (
    input  logic           clock,
    input  logic           reset,
    hit_receiver_if.slave  hif
);
    localparam logic [6:0] HP_INIT = 7'(HP_MAX);
    localparam logic [4:0] KD      = 5'(KNOCK_DIST);
    localparam logic [5:0] HF      = 6'(HOLD_FRAMES);

    typedef enum logic [2:0] {IDLE, PUSH, HOLD, RETURN, DONE} state_t;

    state_t     state, state_nxt;
    logic [4:0] offset, offset_nxt;
    logic [5:0] hold_cnt, hold_cnt_nxt;
    logic [6:0] hp_r, hp_nxt;
    logic       flash_r, flash_nxt;
    logic       fainted_w;

    assign fainted_w = (hp_r == 7'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            offset   <= '0;
            hold_cnt <= '0;
            hp_r     <= HP_INIT;
            flash_r  <= 1'b0;
        end else begin
            state    <= state_nxt;
            offset   <= offset_nxt;
            hold_cnt <= hold_cnt_nxt;
            hp_r     <= hp_nxt;
            flash_r  <= flash_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        offset_nxt   = offset;
        hold_cnt_nxt = hold_cnt;
        hp_nxt       = hp_r;
        flash_nxt    = flash_r;
        unique case (state)
            IDLE: begin
                // a tick arriving with the hit is deliberately not counted
                if (hif.hit_start && !fainted_w) begin
                    state_nxt = PUSH;
                    hp_nxt    = (hif.damage >= hp_r) ? 7'd0 : hp_r - hif.damage;
                end
            end
            PUSH: begin
                if (hif.frame_tick) begin
                    offset_nxt = offset + 5'd1;
                    if (offset + 5'd1 == KD) begin
                        state_nxt = HOLD;
                        flash_nxt = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (hif.frame_tick) begin
                    flash_nxt = ~flash_r;
                    if (hold_cnt + 6'd1 == HF) begin
                        state_nxt    = RETURN;
                        hold_cnt_nxt = '0;
                    end else begin
                        hold_cnt_nxt = hold_cnt + 6'd1;
                    end
                end
            end
            RETURN: begin
                if (hif.frame_tick) begin
                    offset_nxt = offset - 5'd1;
                    if (offset == 5'd1)
                        state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign hif.pos_x   = hif.base_x + {4'd0, offset};
    assign hif.flash   = (state == HOLD) && flash_r;
    assign hif.hp      = hp_r;
    assign hif.busy    = (state == PUSH) || (state == HOLD) || (state == RETURN);
    assign hif.done    = (state == DONE);
    assign hif.fainted = fainted_w;
endmodule

// File: tb/tb_hit_receiver.sv
// Self-checking bench for hit_receiver: reaction-progress model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_hit_receiver;
    localparam int HP_MAX = 100;
    localparam int KD     = 10;
    localparam int HF     = 6;
    localparam int TOTAL  = 2 * KD + HF;

    bit   clock = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;

    hit_receiver_if hif ();

    hit_receiver #(.HP_MAX(HP_MAX), .KNOCK_DIST(KD), .HOLD_FRAMES(HF)) dut (
        .clock (clock),
        .reset (reset),
        .hif   (hif.slave)
    );

    always #5 clock = ~clock;

    // Model: a reaction is "k frame ticks since acceptance"; outputs follow from k.
    bit m_valid = 1'b0;
    bit m_active, m_done;
    int m_k, m_hp;

    always @(posedge clock) begin
        if (reset) begin
            m_valid = 1'b1; m_active = 1'b0; m_done = 1'b0; m_k = 0; m_hp = HP_MAX;
        end else if (m_valid) begin
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_active) begin
                if (hif.frame_tick) begin
                    m_k++;
                    if (m_k == TOTAL) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end
                end
            end else if (hif.hit_start && m_hp != 0) begin
                m_active = 1'b1;
                m_k      = 0;
                m_hp     = (hif.damage >= m_hp) ? 0 : m_hp - int'(hif.damage);
            end
        end
    end

    function automatic int exp_offset();
        if (!m_active)          return 0;
        if (m_k <= KD)          return m_k;
        if (m_k <= KD + HF)     return KD;
        return TOTAL - m_k;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (hif.done === 1'b1) done_cnt++;
        if (m_valid) begin
            check("pos_x",   32'(hif.pos_x), 32'((int'(hif.base_x) + exp_offset()) % 512));
            check("flash",   32'(hif.flash),
                  32'(m_active && m_k >= KD && m_k < KD + HF && ((m_k - KD) % 2 == 0)));
            check("busy",    32'(hif.busy),    32'(m_active));
            check("done",    32'(hif.done),    32'(m_done));
            check("hp",      32'(hif.hp),      32'(m_hp));
            check("fainted", 32'(hif.fainted), 32'(m_hp == 0));
        end
    end

    task automatic cyc(input bit h, input logic [6:0] d, input bit t);
        hif.hit_start  = h;
        hif.damage     = d;
        hif.frame_tick = t;
        @(posedge clock);
        #1;
        hif.hit_start  = 1'b0;
        hif.frame_tick = 1'b0;
    endtask

    task automatic run_ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 7'd0, 1'b1);
            for (int j = 1; j < gap; j++) cyc(1'b0, 7'd0, 1'b0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 7'd0, 1'b0);
        cyc(1'b0, 7'd0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic full_hit(input logic [6:0] d);
        cyc(1'b1, d, 1'b0);
        run_ticks(TOTAL, 1);
        cyc(1'b0, 7'd0, 1'b0);
        cyc(1'b0, 7'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        hif.hit_start = 1'b0; hif.damage = '0; hif.frame_tick = 1'b0; hif.base_x = 9'd100;

        // basic reaction, ticks every 4 clocks
        do_reset();
        check("rst_hp",   32'(hif.hp),    32'd100);
        check("rst_posx", 32'(hif.pos_x), 32'd100);
        check("rst_busy", 32'(hif.busy),  32'd0);
        done_cnt = 0;
        cyc(1'b1, 7'd30, 1'b0);
        check("hit_hp",   32'(hif.hp),   32'd70);
        check("hit_busy", 32'(hif.busy), 32'd1);
        run_ticks(KD, 4);
        check("peak_posx",  32'(hif.pos_x), 32'd110);
        check("peak_flash", 32'(hif.flash), 32'd1);
        run_ticks(HF, 4);
        check("ret_flash", 32'(hif.flash), 32'd0);
        run_ticks(KD - 1, 4);
        cyc(1'b0, 7'd0, 1'b1);
        check("end_done", 32'(hif.done),  32'd1);
        check("end_posx", 32'(hif.pos_x), 32'd100);
        cyc(1'b0, 7'd0, 1'b0);
        check("end_idle", 32'(hif.busy) + 32'(hif.done), 32'd0);
        check("done_once", 32'(done_cnt), 32'd1);

        // drive hp to zero, then a hit while fainted is ignored
        full_hit(7'd30);
        full_hit(7'd30);
        check("hp_10", 32'(hif.hp), 32'd10);
        done_cnt = 0;
        full_hit(7'd25);
        check("faint_hp",   32'(hif.hp),      32'd0);
        check("faint_flag", 32'(hif.fainted), 32'd1);
        check("faint_done", 32'(done_cnt),    32'd1);
        cyc(1'b1, 7'd5, 1'b0);
        check("faint_ign_busy", 32'(hif.busy), 32'd0);
        check("faint_ign_hp",   32'(hif.hp),   32'd0);

        // second hit during HOLD is ignored
        do_reset();
        done_cnt = 0;
        cyc(1'b1, 7'd20, 1'b0);
        run_ticks(KD + 2, 2);
        cyc(1'b1, 7'd40, 1'b0);
        run_ticks(TOTAL - KD - 2, 2);
        cyc(1'b0, 7'd0, 1'b0);
        check("hold_hit_hp",   32'(hif.hp),   32'd80);
        check("hold_hit_done", 32'(done_cnt), 32'd1);

        // reset in RETURN with offset 5
        do_reset();
        done_cnt = 0;
        cyc(1'b1, 7'd15, 1'b0);
        run_ticks(KD + HF + 5, 1);
        check("ret5_posx", 32'(hif.pos_x), 32'd105);
        reset = 1'b1;
        cyc(1'b1, 7'd9, 1'b1);
        reset = 1'b0;
        check("rst_mid_posx",  32'(hif.pos_x), 32'd100);
        check("rst_mid_hp",    32'(hif.hp),    32'd100);
        check("rst_mid_busy",  32'(hif.busy),  32'd0);
        check("rst_mid_flash", 32'(hif.flash), 32'd0);
        cyc(1'b0, 7'd0, 1'b0);
        cyc(1'b0, 7'd0, 1'b0);
        check("rst_mid_nodone", 32'(done_cnt), 32'd0);

        // tick coincident with the hit is not counted
        cyc(1'b1, 7'd10, 1'b1);
        check("coinc_posx", 32'(hif.pos_x), 32'd100);
        check("coinc_busy", 32'(hif.busy),  32'd1);
        cyc(1'b0, 7'd0, 1'b1);
        check("coinc_next", 32'(hif.pos_x), 32'd101);
        run_ticks(TOTAL - 1, 1);
        cyc(1'b0, 7'd0, 1'b0);

        // wrap of pos_x with zero damage
        hif.base_x = 9'd505;
        done_cnt = 0;
        cyc(1'b1, 7'd0, 1'b0);
        run_ticks(KD, 1);
        check("wrap_posx", 32'(hif.pos_x), 32'd3);
        check("wrap_hp",   32'(hif.hp),    32'd90);
        run_ticks(TOTAL - KD, 1);
        cyc(1'b0, 7'd0, 1'b0);
        check("wrap_done", 32'(done_cnt), 32'd1);
        check("wrap_home", 32'(hif.pos_x), 32'd505);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hit_receiver.md
HIT_RECEIVER -- requirements
Module: hit_receiver

Interface
REQ-001 The block SHALL have parameter HP_MAX, default 100, meaning the HP value loaded at reset, range 1..127.
REQ-002 The block SHALL have parameter KNOCK_DIST, default 10, meaning the maximum knockback offset in pixels, range 1..31.
REQ-003 The block SHALL have parameter HOLD_FRAMES, default 6, meaning the number of frame ticks spent at full knockback, range 1..63.
REQ-004 The block SHALL have port clock, input, 1 bit, the system clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port hit_start, input, 1 bit, a one-cycle pulse from the attacker when its sprite makes contact.
REQ-007 The block SHALL have port damage, input, 7 bits, the HP to subtract, sampled in the hit_start cycle.
REQ-008 The block SHALL have port frame_tick, input, 1 bit, a one-cycle pulse per animation frame.
REQ-009 The block SHALL have port base_x, input, 9 bits, the defender sprite home x position.
REQ-010 The block SHALL have port pos_x, output, 9 bits, the current defender x position for the sprite drawer.
REQ-011 The block SHALL have port flash, output, 1 bit; when 1, the drawer substitutes the hit colour.
REQ-012 The block SHALL have port hp, output, 7 bits, the remaining hit points.
REQ-013 The block SHALL have port busy, output, 1 bit, high while a reaction animation is in progress.
REQ-014 The block SHALL have port done, output, 1 bit, a one-cycle pulse when the reaction completes.
REQ-015 The block SHALL have port fainted, output, 1 bit, high when hp equals 0.

Function
REQ-016 The FSM SHALL have the states IDLE, PUSH, HOLD, RETURN and DONE.
REQ-017 In IDLE, a hit_start with fainted=0 SHALL be accepted: next edge enters PUSH; hp <= hp - damage, saturating at 0.
REQ-018 A hit_start outside IDLE, or while fainted=1, SHALL be ignored: no state change and no hp change.
REQ-019 PUSH: each frame_tick SHALL increment the 5-bit offset; the tick that makes offset equal KNOCK_DIST SHALL also move the FSM to HOLD.
REQ-020 HOLD: each frame_tick SHALL increment hold_cnt; the HOLD_FRAMES-th tick SHALL move the FSM to RETURN and clear hold_cnt.
REQ-021 RETURN: each frame_tick SHALL decrement offset; the tick that makes offset 0 SHALL move the FSM to DONE.
REQ-022 DONE SHALL last exactly one clock, with done=1, and SHALL then go to IDLE unconditionally.
REQ-023 Clocks without frame_tick SHALL hold all counters and the state (except DONE).
REQ-024 A frame_tick in the same cycle as an accepted hit_start SHALL NOT advance offset; the first increment is on the next tick.
REQ-025 pos_x SHALL equal base_x + zero-extended offset, combinational, 9-bit modulo 512.
REQ-026 flash SHALL be 1 on HOLD entry and toggle on each frame_tick in HOLD.
REQ-027 flash SHALL be 0 in every state other than HOLD.
REQ-028 busy SHALL be 1 in PUSH, HOLD and RETURN, and 0 in IDLE and DONE.
REQ-029 fainted SHALL be decoded from the hp register (hp==0).
REQ-030 The animation SHALL still run to completion when the hit drives hp to 0.
REQ-031 damage=0 SHALL run the full animation with hp unchanged.
REQ-032 Total reaction length SHALL be 2*KNOCK_DIST+HOLD_FRAMES frame ticks (26 at defaults) plus the one-cycle DONE.

Reset
REQ-033 reset=1 at a clock edge SHALL force state=IDLE, offset=0, hold_cnt=0 and hp=HP_MAX.
REQ-034 Consequently, after reset: pos_x=base_x, flash=0, busy=0, done=0, fainted=0.
REQ-035 reset SHALL take priority over hit_start and frame_tick in the same cycle, including mid-animation.

Verification
REQ-036 Reset, then hit_start with damage=30 and ticks every 4 clocks -> hp=70 one edge later, busy=1; pos_x rises base_x..base_x+10; flash toggles for 6 ticks; pos_x returns to base_x; done pulses once after 26 ticks.
REQ-037 hp=10, hit damage=25 -> hp=0, fainted=1, full animation completes with done pulse; a further hit_start is ignored (hp stays 0, busy stays 0).
REQ-038 Second hit_start during HOLD -> ignored; hp drops by the first damage only; exactly one done pulse.
REQ-039 reset asserted in the RETURN state with offset=5 -> next edge: pos_x=base_x, hp=100, busy=0, flash=0, no done pulse.
REQ-040 hit_start and frame_tick in the same cycle -> offset remains 0 on that edge; offset reaches 1 on the following tick.
REQ-041 base_x=505, peak offset 10 -> pos_x wraps to 3; damage=0 -> hp unchanged, done pulses.
